// File: rtl/csr_regfile_pkg.sv
// Shared CSR constants: addresses, exception codes and field bit positions.
package csr_regfile_pkg;

   localparam logic [13:0] CSR_CRMD      = 14'h000;
   localparam logic [13:0] CSR_PRMD      = 14'h001;
   localparam logic [13:0] CSR_ECFG      = 14'h004;
   localparam logic [13:0] CSR_ESTAT     = 14'h005;
   localparam logic [13:0] CSR_ERA       = 14'h006;
   localparam logic [13:0] CSR_BADV      = 14'h007;
   localparam logic [13:0] CSR_EENTRY    = 14'h00c;
   localparam logic [13:0] CSR_SAVE0     = 14'h030;
   localparam logic [13:0] CSR_SAVE1     = 14'h031;
   localparam logic [13:0] CSR_SAVE2     = 14'h032;
   localparam logic [13:0] CSR_SAVE3     = 14'h033;
   localparam logic [13:0] CSR_TID       = 14'h040;
   localparam logic [13:0] CSR_TCFG      = 14'h041;
   localparam logic [13:0] CSR_TVAL      = 14'h042;
   localparam logic [13:0] CSR_TICLR     = 14'h044;
   localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_TLBR = 6'h3f;

   localparam int CRMD_IE   = 2;
   localparam int CRMD_DA   = 3;
   localparam int CRMD_PG   = 4;
   localparam int ESTAT_TI  = 11;

   // Exceptions that report a faulting address in BADV.
   function automatic logic ecode_has_badv(input logic [5:0] ec);
      return (ec == ECODE_ADEF) || (ec == ECODE_ALE) || (ec == ECODE_TLBR) ||
             ((ec > ECODE_INT) && (ec < ECODE_ADEF));
   endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// WB-stage request bus into the CSR file: CSR access, exception commit, ertn.
interface csr_regfile_if;
   logic        csr_re;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_ex_pc;
   logic [31:0] wb_badv;
   logic        ertn_flush;

   modport master (
      output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
             wb_ex, wb_ecode, wb_esubcode, wb_ex_pc, wb_badv, ertn_flush,
      input  csr_rvalue
   );

   modport slave (
      input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
             wb_ex, wb_ecode, wb_esubcode, wb_ex_pc, wb_badv, ertn_flush,
      output csr_rvalue
   );
endinterface

// File: rtl/csr_regfile_timer.sv
// TCFG/TVAL countdown timer raising ESTAT.IS[11]; built only with `define CSR_TIMER_EN.
`ifdef CSR_TIMER_EN
module csr_regfile_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_we,
   input  logic [31:0] cfg_wdata,
   input  logic        ti_clr,
   output logic [31:0] tcfg,
   output logic [31:0] tval,
   output logic        timer_set
);
   localparam int TCFG_EN       = 0;
   localparam int TCFG_PERIODIC = 1;

   logic en;
   assign en = tcfg[TCFG_EN];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcfg      <= '0;
         tval      <= '0;
         timer_set <= 1'b0;
      end else begin
         if (cfg_we) tcfg <= cfg_wdata;
         if (cfg_we && cfg_wdata[TCFG_EN])
            tval <= {cfg_wdata[31:2], 2'b00};
         else if (en && tval != 32'd0)
            tval <= tval - 32'd1;
         else if (en && tcfg[TCFG_PERIODIC])
            tval <= {tcfg[31:2], 2'b00};
         // The 1->0 step sets the flag; a same-cycle clear loses.
         if (en && tval == 32'd1)
            timer_set <= 1'b1;
         else if (ti_clr)
            timer_set <= 1'b0;
      end
   end
endmodule
`endif

// File: rtl/csr_regfile.sv
// Control/status register file serving WB-stage CSR access, exception commit and ertn.
// Optional timer CSRs (TID/TCFG/TVAL/TICLR) are enabled by `define CSR_TIMER_EN.
module csr_regfile
   import csr_regfile_pkg::*;
#(
   parameter logic [31:0] TID_RESET = 32'h0,
   parameter int          DATA_W    = 32
) (
   input  logic         clk,
   input  logic         reset,
   csr_regfile_if.slave bus,
   input  logic [7:0]   hw_int_in,
   input  logic         ipi_int_in,
   output logic         has_int,
   output logic [31:0]  era_out,
   output logic [1:0]   crmd_plv,
   output logic [1:0]   crmd_da_pg
);
   logic [DATA_W-1:0]      crmd, prmd, ecfg, estat, era, badv, eentry, tlbrentry;
   logic [3:0][DATA_W-1:0] save;
   logic [DATA_W-1:0]      estat_v, rdata, wmerged;
   logic                   ti_is, csr_wr;

   // Exception and ertn drop any same-cycle CSR write.
   assign csr_wr  = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
   assign wmerged = (bus.csr_wvalue & bus.csr_wmask) | (rdata & ~bus.csr_wmask);

`ifdef CSR_TIMER_EN
   logic [DATA_W-1:0] tid, tcfg, tval;

   csr_regfile_timer u_csr_timer (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (csr_wr && bus.csr_num == CSR_TCFG),
      .cfg_wdata (wmerged),
      .ti_clr    (csr_wr && bus.csr_num == CSR_TICLR && bus.csr_wmask[0] && bus.csr_wvalue[0]),
      .tcfg      (tcfg),
      .tval      (tval),
      .timer_set (ti_is)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 tid <= TID_RESET;
      else if (csr_wr && bus.csr_num == CSR_TID) tid <= wmerged;
   end
`else
   logic unused_tid;
   assign unused_tid = ^TID_RESET;
   assign ti_is      = 1'b0;
`endif

   logic unused_re;
   assign unused_re = bus.csr_re;

   // IS[11] lives in the timer; splice it into the architectural view.
   assign estat_v = {estat[DATA_W-1:ESTAT_TI+1], ti_is, estat[ESTAT_TI-1:0]};

   always_comb begin
      rdata = '0;
      case (bus.csr_num)
         CSR_CRMD:      rdata = crmd;
         CSR_PRMD:      rdata = prmd;
         CSR_ECFG:      rdata = ecfg;
         CSR_ESTAT:     rdata = estat_v;
         CSR_ERA:       rdata = era;
         CSR_BADV:      rdata = badv;
         CSR_EENTRY:    rdata = eentry;
         CSR_SAVE0:     rdata = save[0];
         CSR_SAVE1:     rdata = save[1];
         CSR_SAVE2:     rdata = save[2];
         CSR_SAVE3:     rdata = save[3];
         CSR_TLBRENTRY: rdata = tlbrentry;
`ifdef CSR_TIMER_EN
         CSR_TID:       rdata = tid;
         CSR_TCFG:      rdata = tcfg;
         CSR_TVAL:      rdata = tval;
`else
         CSR_TID, CSR_TCFG, CSR_TVAL: rdata = '0;
`endif
         CSR_TICLR:     rdata = '0;
         default:       rdata = '0;
      endcase
   end
   assign bus.csr_rvalue = rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crmd      <= DATA_W'(32'h8);
         prmd      <= '0;
         ecfg      <= '0;
         estat     <= '0;
         era       <= '0;
         badv      <= '0;
         eentry    <= '0;
         save      <= '0;
         tlbrentry <= '0;
      end else begin
         estat[9:2] <= hw_int_in;
         estat[12]  <= ipi_int_in;
         if (bus.wb_ex) begin
            prmd[2:0]    <= crmd[2:0];
            crmd[2:0]    <= 3'b000;
            era          <= bus.wb_ex_pc;
            estat[21:16] <= bus.wb_ecode;
            estat[30:22] <= bus.wb_esubcode;
            if (ecode_has_badv(bus.wb_ecode)) badv <= bus.wb_badv;
            if (bus.wb_ecode == ECODE_TLBR) begin
               crmd[CRMD_DA] <= 1'b1;
               crmd[CRMD_PG] <= 1'b0;
            end
         end else if (bus.ertn_flush) begin
            crmd[2:0] <= prmd[2:0];
            if (estat[21:16] == ECODE_TLBR) begin
               crmd[CRMD_DA] <= 1'b0;
               crmd[CRMD_PG] <= 1'b1;
            end
         end else if (csr_wr) begin
            case (bus.csr_num)
               CSR_CRMD:      crmd[8:0] <= wmerged[8:0];
               CSR_PRMD:      prmd[2:0] <= wmerged[2:0];
               CSR_ECFG: begin
                  ecfg[9:0]   <= wmerged[9:0];
                  ecfg[12:11] <= wmerged[12:11];
               end
               CSR_ESTAT:     estat[1:0] <= wmerged[1:0];
               CSR_ERA:       era <= wmerged;
               CSR_BADV:      badv <= wmerged;
               CSR_EENTRY:    eentry[31:6] <= wmerged[31:6];
               CSR_SAVE0:     save[0] <= wmerged;
               CSR_SAVE1:     save[1] <= wmerged;
               CSR_SAVE2:     save[2] <= wmerged;
               CSR_SAVE3:     save[3] <= wmerged;
               CSR_TLBRENTRY: tlbrentry[31:6] <= wmerged[31:6];
               default: ;
            endcase
         end
      end
   end

   assign has_int    = crmd[CRMD_IE] & |(estat_v[12:0] & ecfg[12:0]);
   assign era_out    = era;
   assign crmd_plv   = crmd[1:0];
   assign crmd_da_pg = {crmd[CRMD_DA], crmd[CRMD_PG]};

endmodule
